// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and the single-byte reflected CRC-32 step
// used by the crc32_stream engine.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Eight LSB-first bit steps of the reflected CRC-32 update for one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] reg32,
                                             input logic [7:0]  byte8,
                                             input logic [31:0] poly = CRC32_POLY_REFL);
    logic [31:0] r;
    r = reg32;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (poly & {32{r[0] ^ byte8[i]}});
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_comb.sv
// Combinational multi-byte CRC-32 update: bytes are folded in ascending index
// order and a byte whose keep bit is low passes the register through unchanged.
module crc32_comb
  import crc_pkg::*;
#(
  parameter int          KEEP_WIDTH = 1,
  parameter logic [31:0] POLY_REFL  = CRC32_POLY_REFL
) (
  input  logic [31:0]             crc_i,
  input  logic [8*KEEP_WIDTH-1:0] data_i,
  input  logic [KEEP_WIDTH-1:0]   keep_i,
  output logic [31:0]             crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      if (keep_i[k]) begin
        crc_o = crc32_byte(crc_o, data_i[8*k +: 8], POLY_REFL);
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine: generate mode emits the FCS, check mode
// tests the residue and feeds saturating good/bad frame counters.
module crc32_stream
  import crc_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] POLY_REFL  = CRC32_POLY_REFL,
  parameter logic [31:0] INIT       = CRC32_INIT,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic                    crc_clear,
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic                    crc_ok,
  output logic                    keep_err,
  output logic [CNT_WIDTH-1:0]    good_cnt,
  output logic [CNT_WIDTH-1:0]    bad_cnt
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  state_t                 state_q, state_d;
  logic [31:0]            crc_q, crc_d, crc_next;
  logic                   mode_q, mode_d;
  logic                   err_q, err_d;
  logic [31:0]            out_q, out_d;
  logic                   vld_q, vld_d;
  logic                   ok_q, ok_d;
  logic                   kerr_q, kerr_d;
  logic [CNT_WIDTH-1:0]   good_q, good_d;
  logic [CNT_WIDTH-1:0]   bad_q, bad_d;

  logic keep_full, keep_contig, keep_bad, mode_eff, err_eff;

  crc32_comb #(
    .KEEP_WIDTH(KEEP_WIDTH),
    .POLY_REFL (POLY_REFL)
  ) u_comb (
    .crc_i (crc_q),
    .data_i(s_data),
    .keep_i(s_keep),
    .crc_o (crc_next)
  );

  // A legal last-beat keep is a non-empty run of ones starting at bit 0.
  assign keep_full   = &s_keep;
  assign keep_contig = s_keep[0] && ((s_keep & (s_keep + KEEP_WIDTH'(1))) == '0);
  assign keep_bad    = s_last ? !keep_contig : !keep_full;

  assign mode_eff = (state_q == IDLE) ? mode : mode_q;
  assign err_eff  = ((state_q == ACTIVE) && err_q) || keep_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_valid && !crc_clear && !s_last) state_d = ACTIVE;
      ACTIVE:  if (crc_clear || (s_valid && s_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a coincident beat; a last beat reloads INIT so the
  // next frame may start on the very next cycle.
  always_comb begin
    crc_d  = crc_q;
    mode_d = mode_q;
    err_d  = err_q;
    out_d  = out_q;
    ok_d   = ok_q;
    vld_d  = 1'b0;
    kerr_d = 1'b0;
    good_d = good_q;
    bad_d  = bad_q;
    if (crc_clear) begin
      crc_d = INIT;
      err_d = 1'b0;
    end else if (s_valid) begin
      kerr_d = keep_bad;
      if (s_last) begin
        crc_d = INIT;
        err_d = 1'b0;
        vld_d = 1'b1;
        out_d = ~crc_next;
        ok_d  = (crc_next == RESIDUE) && mode_eff && !err_eff;
        if (mode_eff) begin
          if (ok_d) begin
            if (good_q != '1) good_d = good_q + CNT_WIDTH'(1);
          end else begin
            if (bad_q != '1) bad_d = bad_q + CNT_WIDTH'(1);
          end
        end
      end else begin
        crc_d  = crc_next;
        err_d  = err_eff;
        mode_d = mode_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q  <= INIT;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ok_q   <= 1'b0;
      kerr_q <= 1'b0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      crc_q  <= crc_d;
      mode_q <= mode_d;
      err_q  <= err_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      ok_q   <= ok_d;
      kerr_q <= kerr_d;
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign crc_out   = out_q;
  assign crc_valid = vld_q;
  assign crc_ok    = ok_q;
  assign keep_err  = kerr_q;
  assign good_cnt  = good_q;
  assign bad_cnt   = bad_q;

endmodule
